// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-decode helpers for the lsu_rmw load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Unsigned sub-word codes exist only for loads.
    function automatic logic f3_reserved(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_H, F3_HU: return lane[0];
            F3_W:        return |lane;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] force_align(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_H, F3_HU: return {lane[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return lane;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extraction/extension and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [BYTE_W-1:0] byte_val;
    logic [HALF_W-1:0] half_val;
    logic [WORD_W-1:0] byte_mask;
    logic [WORD_W-1:0] half_mask;

    assign byte_sh   = {lane, 3'b000};
    assign half_sh   = {lane[1], 4'b0000};
    assign byte_val  = old_word[byte_sh +: BYTE_W];
    assign half_val  = old_word[half_sh +: HALF_W];
    assign byte_mask = 32'h0000_00FF << byte_sh;
    assign half_mask = 32'h0000_FFFF << half_sh;

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{(WORD_W-BYTE_W){byte_val[BYTE_W-1]}}, byte_val};
            F3_BU:   load_data = {{(WORD_W-BYTE_W){1'b0}}, byte_val};
            F3_H:    load_data = {{(WORD_W-HALF_W){half_val[HALF_W-1]}}, half_val};
            F3_HU:   load_data = {{(WORD_W-HALF_W){1'b0}}, half_val};
            F3_W:    load_data = old_word;
            default: load_data = '0;
        endcase
    end

    // Untouched lanes of the old word pass through unchanged.
    always_comb begin
        merged = old_word;
        case (funct3)
            F3_B:    merged = (old_word & ~byte_mask) | ((wdata & 32'h0000_00FF) << byte_sh);
            F3_H:    merged = (old_word & ~half_mask) | ((wdata & 32'h0000_FFFF) << half_sh);
            F3_W:    merged = wdata;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// RISC-V load/store unit for a word-only memory; sub-word stores use read-modify-write.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses error instead of being forced aligned.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          req_err;
    logic [1:0]    req_lane;
    logic [2:0]    cap_f3;
    logic [1:0]    cap_lane;
    logic [DW-1:0] cap_wdata;
    logic [DW-1:0] merge_q;
    logic [DW-1:0] old_word;
    logic [DW-1:0] load_data;
    logic [DW-1:0] merged;

    assign req_ready  = (state == S_IDLE);
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == S_RESP);
    assign mem_we     = (state == S_WRITE);
    assign mem_wd     = mem_we ? merged : '0;
    assign old_word   = (state == S_LOAD) ? mem_rd : merge_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err  = f3_reserved(req_we, req_funct3) | misaligned(req_funct3, req_addr[1:0]);
    assign req_lane = req_addr[1:0];
`else
    assign req_err  = f3_reserved(req_we, req_funct3);
    assign req_lane = force_align(req_funct3, req_addr[1:0]);
`endif

    lsu_lane_align u_align (
        .funct3    (cap_f3),
        .lane      (cap_lane),
        .old_word  (old_word),
        .wdata     (cap_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                state_nxt = S_RESP;
                    else if (!req_we)           state_nxt = S_LOAD;
                    else if (req_funct3 == F3_W) state_nxt = S_WRITE;
                    else                        state_nxt = S_RMW_RD;
                end
            end
            S_LOAD:   state_nxt = S_RESP;
            S_RMW_RD: state_nxt = S_WRITE;
            S_WRITE:  state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_f3     <= '0;
            cap_lane   <= '0;
            cap_wdata  <= '0;
            merge_q    <= '0;
            mem_addr   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_f3     <= req_funct3;
                cap_lane   <= req_lane;
                cap_wdata  <= req_wdata;
                resp_err   <= req_err;
                resp_rdata <= '0;
                // Error requests never touch memory, so the address bus keeps its old value.
                if (!req_err) mem_addr <= {req_addr[AW-1:2], 2'b00};
            end
            if (state == S_LOAD)   resp_rdata <= load_data;
            if (state == S_RMW_RD) merge_q    <= mem_rd;
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed table-driven bench for lsu_rmw with a 64-word memory model.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [64];
    int          wr_count = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    lsu_rmw #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = (mem_addr < 32'd256) ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_we) begin
            wr_count <= wr_count + 1;
            if (mem_addr < 32'd256) mem[mem_addr[7:2]] <= mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          writes;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic err, input logic [31:0] rd,
                       input int wr);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.lat = lat; v.err = err; v.rdata = rd; v.writes = wr;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int wr0;
        int we_cycles;
        @(negedge clk);
        check({v.name, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        wr0 = wr_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        we_cycles = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_we) we_cycles++;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            failures++; checks++;
            $display("FAIL %s timeout: no resp_valid within 8 cycles", v.name);
        end else begin
            check({v.name, " latency"}, lat, v.lat);
            check({v.name, " err"}, {31'b0, resp_err}, {31'b0, v.err});
            check({v.name, " rdata"}, resp_rdata, v.rdata);
        end
        @(negedge clk);
        check({v.name, " pulse end"}, {31'b0, resp_valid}, 32'd0);
        check({v.name, " writes"}, wr_count - wr0, v.writes);
        check({v.name, " we cycles"}, we_cycles, v.writes);
    endtask

    vec_t bb[4];
    logic [31:0] bb_exp [4];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'hFACE_FACE;
        mem[1] = 32'h0000_0002;
        mem[2] = 32'h0000_0003;

        // Reset state.
        #12;
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err", {31'b0, resp_err}, 32'd0);
        check("rst mem_we", {31'b0, mem_we}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wd", mem_wd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        add("LB 0",      0, 3'b000, 32'h00, 32'h0,         2, 0, 32'hFFFF_FFCE, 0);
        add("LBU 1",     0, 3'b100, 32'h01, 32'h0,         2, 0, 32'h0000_00FA, 0);
        add("LH 2",      0, 3'b001, 32'h02, 32'h0,         2, 0, 32'hFFFF_FACE, 0);
        add("LHU 2",     0, 3'b101, 32'h02, 32'h0,         2, 0, 32'h0000_FACE, 0);
        add("SB 3",      1, 3'b000, 32'h03, 32'h0000_0012, 3, 0, 32'h0,         1);
        add("LW 0",      0, 3'b010, 32'h00, 32'h0,         2, 0, 32'h12CE_FACE, 0);
        add("SH 4",      1, 3'b001, 32'h04, 32'h0000_ABCD, 3, 0, 32'h0,         1);
        add("LW 4",      0, 3'b010, 32'h04, 32'h0,         2, 0, 32'h0000_ABCD, 0);
        add("SW FC",     1, 3'b010, 32'hFC, 32'hFACE_FACE, 2, 0, 32'h0,         1);
        add("LW FC",     0, 3'b010, 32'hFC, 32'h0,         2, 0, 32'hFACE_FACE, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        add("LH 1 mis",  0, 3'b001, 32'h01, 32'h0,         1, 1, 32'h0,         0);
`else
        add("LH 1 mis",  0, 3'b001, 32'h01, 32'h0,         2, 0, 32'hFFFF_FACE, 0);
`endif
        add("SW f3=011", 1, 3'b011, 32'h00, 32'h1111_1111, 1, 1, 32'h0,         0);
        add("LD f3=011", 0, 3'b011, 32'h00, 32'h0,         1, 1, 32'h0,         0);
        add("ST f3=100", 1, 3'b100, 32'h00, 32'h2222_2222, 1, 1, 32'h0,         0);
        add("LD f3=111", 0, 3'b111, 32'h00, 32'h0,         1, 1, 32'h0,         0);
        add("LB 3",      0, 3'b000, 32'h03, 32'h0,         2, 0, 32'h0000_0012, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        add("SW 6 mis",  1, 3'b010, 32'h06, 32'h1122_3344, 1, 1, 32'h0,         0);
        add("LW 4 post", 0, 3'b010, 32'h04, 32'h0,         2, 0, 32'h0000_ABCD, 0);
`else
        add("SW 6 mis",  1, 3'b010, 32'h06, 32'h1122_3344, 2, 0, 32'h0,         1);
        add("LW 4 post", 0, 3'b010, 32'h04, 32'h0,         2, 0, 32'h1122_3344, 0);
`endif

        foreach (vecs[i]) run_vec(vecs[i]);
        check("word0 final", mem[0], 32'h12CE_FACE);
        check("word63 final", mem[63], 32'hFACE_FACE);

        // Reset during RMW_RD of an SB to word 2.
        @(negedge clk);
        begin
            int wr0;
            wr0 = wr_count;
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h08; req_wdata = 32'h55;
            @(posedge clk);
            #1 req_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check("midrst mem_we", {31'b0, mem_we}, 32'd0);
            check("midrst req_ready", {31'b0, req_ready}, 32'd1);
            check("midrst resp_valid", {31'b0, resp_valid}, 32'd0);
            check("midrst resp_err", {31'b0, resp_err}, 32'd0);
            check("midrst resp_rdata", resp_rdata, 32'd0);
            check("midrst mem_addr", mem_addr, 32'd0);
            check("midrst mem_wd", mem_wd, 32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            check("midrst writes", wr_count - wr0, 0);
            check("midrst word2", mem[2], 32'h0000_0003);
            check("midrst ready after", {31'b0, req_ready}, 32'd1);
            check("midrst no resp", {31'b0, resp_valid}, 32'd0);
        end

        // Back-to-back with req_valid held high.
        bb[0].we = 1; bb[0].f3 = 3'b010; bb[0].addr = 32'h10; bb[0].wdata = 32'hA5A5_A5A5;
        bb[1].we = 0; bb[1].f3 = 3'b100; bb[1].addr = 32'h11; bb[1].wdata = 32'h0;
        bb[2].we = 1; bb[2].f3 = 3'b000; bb[2].addr = 32'h12; bb[2].wdata = 32'h0000_003C;
        bb[3].we = 0; bb[3].f3 = 3'b010; bb[3].addr = 32'h10; bb[3].wdata = 32'h0;
        bb_exp[0] = 32'h0; bb_exp[1] = 32'h0000_00A5; bb_exp[2] = 32'h0; bb_exp[3] = 32'hA53C_A5A5;
        begin
            int sent;
            int got;
            int wr0;
            sent = 0; got = 0; wr0 = wr_count;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                @(negedge clk);
                if (resp_valid) begin
                    if (got < 4) begin
                        check($sformatf("bb%0d rdata", got), resp_rdata, bb_exp[got]);
                        check($sformatf("bb%0d err", got), {31'b0, resp_err}, 32'd0);
                    end
                    got++;
                end
                if (sent < 4) begin
                    req_valid = 1'b1; req_we = bb[sent].we; req_funct3 = bb[sent].f3;
                    req_addr = bb[sent].addr; req_wdata = bb[sent].wdata;
                    if (req_ready) sent++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            req_valid = 1'b0;
            repeat (3) @(negedge clk);
            check("bb responses", got, 4);
            check("bb extra resp", {31'b0, resp_valid}, 32'd0);
            check("bb writes", wr_count - wr0, 2);
            check("bb word4", mem[4], 32'hA53C_A5A5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
